// File: rtl/line_mem_if.sv
// Command/response handshake between the cache refill/evict logic (master)
// and the line memory controller (slave).
interface line_mem_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_cmd;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] req_wb_addr;
    logic [LINE_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [LINE_W-1:0] resp_data;

    modport master (
        output req_valid, req_cmd, req_addr, req_wb_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_cmd, req_addr, req_wb_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/line_mem_ctrl.sv
// Line memory controller: runs one READ / WRITE / WB_FILL command at a time
// against a 128-bit line memory with modelled read and write latency.
module line_mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    line_mem_if.slave         bus,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [LINE_W-1:0] mem_wd,
    input  logic [LINE_W-1:0] mem_rd
);
    localparam int MAXL = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CW   = $clog2(MAXL + 1);
    localparam logic [ADDR_W-1:0] LMASK = ~ADDR_W'(LINE_W / 8 - 1);

    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_WBF   = 2'b10;

    typedef enum logic [2:0] {IDLE, WR_WAIT, WR, RD_WAIT, RESP} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              is_wb_q;
    logic [ADDR_W-1:0] raddr_q;
    logic [ADDR_W-1:0] wtgt_q;
    logic [LINE_W-1:0] wd_q;
    logic [LINE_W-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            is_wb_q <= 1'b0;
            raddr_q <= '0;
            wtgt_q  <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    // WRITE targets req_addr for both read and write address so
                    // mem_a stays on the written line while the response is held.
                    raddr_q <= bus.req_addr & LMASK;
                    wtgt_q  <= ((bus.req_cmd == CMD_WBF) ? bus.req_wb_addr : bus.req_addr) & LMASK;
                    wd_q    <= bus.req_wdata;
                    is_wb_q <= (bus.req_cmd == CMD_WBF);
                    if (bus.req_cmd == CMD_WRITE || bus.req_cmd == CMD_WBF) begin
                        state <= WR_WAIT;
                        cnt   <= CW'(WR_LAT - 1);
                    end else begin
                        state <= RD_WAIT;
                        cnt   <= CW'(RD_LAT - 1);
                    end
                end
                WR_WAIT: begin
                    if (cnt == '0) state <= WR;
                    else           cnt   <= cnt - CW'(1);
                end
                WR: begin
                    if (is_wb_q) begin
                        state <= RD_WAIT;
                        cnt   <= CW'(RD_LAT - 1);
                    end else begin
                        rdata_q <= '0;
                        state   <= RESP;
                    end
                end
                RD_WAIT: begin
                    if (cnt == '0) begin
                        rdata_q <= mem_rd;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP:    if (bus.resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_data  = rdata_q;
    assign mem_we         = (state == WR);
    assign mem_wd         = wd_q;

    always_comb begin
        mem_a = '0;
        case (state)
            WR_WAIT, WR:   mem_a = wtgt_q;
            RD_WAIT, RESP: mem_a = raddr_q;
            default:       mem_a = '0;
        endcase
    end
endmodule

// File: tb/tb_line_mem_ctrl.sv
// Directed-vector and random-stream bench for line_mem_ctrl against a
// 256-line memory model (async read, sync write) and a reference line array.
module tb_line_mem_ctrl;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [LINE_W-1:0] mem_wd;
    logic [LINE_W-1:0] mem_rd;

    logic [LINE_W-1:0] mem     [256];
    logic [LINE_W-1:0] ref_mem [256];

    int n_cmp = 0;
    int n_bad = 0;

    line_mem_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    line_mem_ctrl #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .RD_LAT(2), .WR_LAT(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus.slave),
        .mem_we (mem_we),
        .mem_a  (mem_a),
        .mem_wd (mem_wd),
        .mem_rd (mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[11:4]];
    always @(posedge clk) if (mem_we) mem[mem_a[11:4]] <= mem_wd;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference semantics of one command: expected response data and latency.
    task automatic model(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] wb,
                         input logic [127:0] wd, output logic [127:0] exp, output int lat);
        case (cmd)
            2'b01: begin ref_mem[a[11:4]] = wd; exp = '0; lat = 3; end
            2'b10: begin ref_mem[wb[11:4]] = wd; exp = ref_mem[a[11:4]]; lat = 5; end
            default: begin exp = ref_mem[a[11:4]]; lat = 2; end
        endcase
    endtask

    task automatic run_cmd(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] wb,
                           input logic [127:0] wd, input logic [127:0] exp, input int lat,
                           input string tag);
        int k = 0;
        int nwe = 0;
        logic [31:0] wea = '0;
        bit got = 0;
        logic [31:0] exp_wea;
        exp_wea = ((cmd == 2'b10) ? wb : a) & 32'hFFFF_FFF0;
        @(negedge clk);
        chk({tag, ".req_ready"}, 128'(bus.req_ready), 128'(1));
        bus.req_valid = 1'b1; bus.req_cmd = cmd; bus.req_addr = a;
        bus.req_wb_addr = wb; bus.req_wdata = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        while (k < 20) begin
            @(negedge clk);
            if (bus.resp_valid) begin got = 1; break; end
            if (mem_we) begin nwe++; wea = mem_a; end
            k++;
        end
        chk({tag, ".resp_seen"}, 128'(got), 128'(1));
        chk({tag, ".latency"}, 128'(k), 128'(lat));
        chk({tag, ".resp_data"}, bus.resp_data, exp);
        chk({tag, ".we_pulses"}, 128'(nwe), 128'((cmd == 2'b01 || cmd == 2'b10) ? 1 : 0));
        if (cmd == 2'b01 || cmd == 2'b10) chk({tag, ".we_addr"}, 128'(wea), 128'(exp_wea));
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        @(negedge clk);
        chk({tag, ".idle_after"}, 128'({bus.resp_valid, bus.req_ready}), 128'(2'b01));
    endtask

    typedef struct {
        logic [1:0]   cmd;
        logic [31:0]  addr;
        logic [31:0]  wb;
        logic [127:0] wd;
        logic [127:0] exp;
        int           lat;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [127:0] e;
        int l;
        bit seen;
        bus.req_valid = 0; bus.req_cmd = 0; bus.req_addr = 0; bus.req_wb_addr = 0;
        bus.req_wdata = 0; bus.resp_ready = 0;
        for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        mem[8'h10] = {16{8'hA5}}; ref_mem[8'h10] = {16{8'hA5}};
        mem[8'h31] = 128'h77;     ref_mem[8'h31] = 128'h77;

        tbl[0] = '{2'b00, 32'h100, 32'h0,   128'h0,    {16{8'hA5}}, 2};
        tbl[1] = '{2'b01, 32'h20C, 32'h0,   128'h1234, 128'h0,      3};
        tbl[2] = '{2'b00, 32'h200, 32'h0,   128'h0,    128'h1234,   2};
        tbl[3] = '{2'b10, 32'h310, 32'h300, 128'hBEEF, 128'h77,     5};
        tbl[4] = '{2'b10, 32'h300, 32'h300, 128'hBEEF, 128'hBEEF,   5};
        tbl[5] = '{2'b10, 32'h40F, 32'h404, 128'hD00D, 128'hD00D,   5};
        tbl[6] = '{2'b11, 32'h105, 32'h0,   128'h0,    {16{8'hA5}}, 2};

        #2;
        chk("rst.req_ready",  128'(bus.req_ready), 128'(1));
        chk("rst.resp_valid", 128'(bus.resp_valid), 128'(0));
        chk("rst.resp_data",  bus.resp_data, 128'(0));
        chk("rst.mem_we",     128'(mem_we), 128'(0));
        chk("rst.mem_a",      128'(mem_a), 128'(0));
        chk("rst.mem_wd",     mem_wd, 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            model(tbl[i].cmd, tbl[i].addr, tbl[i].wb, tbl[i].wd, e, l);
            run_cmd(tbl[i].cmd, tbl[i].addr, tbl[i].wb, tbl[i].wd, tbl[i].exp, tbl[i].lat,
                    $sformatf("vec%0d", i));
        end

        // Backpressure: response held, extra request ignored.
        @(negedge clk);
        bus.req_valid = 1; bus.req_cmd = 2'b00; bus.req_addr = 32'h100;
        @(posedge clk);
        #1 bus.req_cmd = 2'b01; bus.req_wdata = 128'hDEAD;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); seen = bus.resp_valid; end
        chk("bp.resp_seen", 128'(seen), 128'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("bp.hold%0d", i),
                {bus.resp_data[124:0], bus.resp_valid, bus.req_ready, mem_we},
                {{16{8'hA5}} << 3} | 128'b100);
        end
        bus.req_valid = 0; bus.resp_ready = 1;
        @(posedge clk);
        #1 bus.resp_ready = 0;
        @(negedge clk);
        chk("bp.idle", 128'({bus.resp_valid, bus.req_ready}), 128'(2'b01));
        run_cmd(2'b00, 32'h100, 0, 0, {16{8'hA5}}, 2, "bp.reread");

        // Reset asserted while mem_we is high.
        @(negedge clk);
        bus.req_valid = 1; bus.req_cmd = 2'b01; bus.req_addr = 32'h500; bus.req_wdata = 128'h55;
        @(posedge clk);
        #1 bus.req_valid = 0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin @(negedge clk); seen = mem_we; end
        chk("rst_wr.we_seen", 128'(seen), 128'(1));
        #2 rst_n = 0;
        #1;
        chk("rst_wr.mem_we",     128'(mem_we), 128'(0));
        chk("rst_wr.resp_valid", 128'(bus.resp_valid), 128'(0));
        chk("rst_wr.req_ready",  128'(bus.req_ready), 128'(1));
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (5) begin
            @(negedge clk);
            chk("rst_wr.no_resp", 128'(bus.resp_valid), 128'(0));
        end
        run_cmd(2'b00, 32'h500, 0, 0, 128'h0, 2, "rst_wr.read_dropped");
        run_cmd(2'b00, 32'h100, 0, 0, {16{8'hA5}}, 2, "rst_wr.read_ok");

        // Random command stream against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]   c;
            logic [31:0]  a, w;
            logic [127:0] d;
            c = 2'($urandom_range(0, 3));
            a = {20'h0, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            w = {20'h0, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            d = {$urandom, $urandom, $urandom, $urandom};
            model(c, a, w, d, e, l);
            run_cmd(c, a, w, d, e, l, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
